// File: rtl/raster_bbox_walker_if.sv
// Triangle-in / pixel-out bus of the raster bounding-box walker.
// The walker sits on the slave side; the triangle source and the pixel
// consumer (or a bench standing in for both) sit on the master side.
interface raster_bbox_walker_if #(
  parameter int XWIDTH     = 24,
  parameter int YWIDTH     = 24,
  parameter int VAL_WIDTH  = 16,
  parameter int AINV_WIDTH = 16,
  parameter int HWIDTH     = 9,
  parameter int VWIDTH     = 8
);
  // triangle handshake and payload
  logic                    tri_valid_in;
  logic                    tri_ready_out;
  logic [3*XWIDTH-1:0]     x_tri_in;
  logic [3*YWIDTH-1:0]     y_tri_in;
  logic [3*VAL_WIDTH-1:0]  vals_in;
  logic [AINV_WIDTH-1:0]   iarea_in;

  // pixel stream
  logic                    pix_valid_out;
  logic                    pix_ready_in;
  logic [HWIDTH-1:0]       hcount_out;
  logic [VWIDTH-1:0]       vcount_out;
  logic [XWIDTH-1:0]       x_out;
  logic [YWIDTH-1:0]       y_out;
  logic                    pix_last_out;

  // triangle data held for the whole walk, plus completion pulse
  logic [3*XWIDTH-1:0]     x_tri_out;
  logic [3*YWIDTH-1:0]     y_tri_out;
  logic [3*VAL_WIDTH-1:0]  vals_out;
  logic [AINV_WIDTH-1:0]   iarea_out;
  logic                    tri_done_out;

  modport slave (
    input  tri_valid_in, x_tri_in, y_tri_in, vals_in, iarea_in, pix_ready_in,
    output tri_ready_out, pix_valid_out, hcount_out, vcount_out, x_out, y_out,
           pix_last_out, x_tri_out, y_tri_out, vals_out, iarea_out, tri_done_out
  );

  modport master (
    output tri_valid_in, x_tri_in, y_tri_in, vals_in, iarea_in, pix_ready_in,
    input  tri_ready_out, pix_valid_out, hcount_out, vcount_out, x_out, y_out,
           pix_last_out, x_tri_out, y_tri_out, vals_out, iarea_out, tri_done_out
  );
endinterface

// File: rtl/raster_bbox_walker.sv
// Raster bounding-box walker: accepts one triangle, computes its screen-clamped
// integer bounding box and streams every pixel of that box in raster order,
// while holding the triangle data steady for the downstream interpolator.
module raster_bbox_walker #(
  parameter int XWIDTH     = 24,
  parameter int YWIDTH     = 24,
  parameter int FRAC       = 14,
  parameter int VAL_WIDTH  = 16,
  parameter int AINV_WIDTH = 16,
  parameter int HRES       = 320,
  parameter int VRES       = 180,
  parameter int HWIDTH     = $clog2(HRES),
  parameter int VWIDTH     = $clog2(VRES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  raster_bbox_walker_if.slave   bus
);

  // Sample coordinates are the counters shifted left by FRAC and must stay
  // positive inside the signed output width.
  if (HWIDTH + FRAC >= XWIDTH) begin : g_xwidth_check
    $error("raster_bbox_walker: HWIDTH+FRAC must be below XWIDTH");
  end
  if (VWIDTH + FRAC >= YWIDTH) begin : g_ywidth_check
    $error("raster_bbox_walker: VWIDTH+FRAC must be below YWIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WALK  = 2'd2
  } state_t;

  localparam logic signed [XWIDTH-1:0] X_ZERO = '0;
  localparam logic signed [YWIDTH-1:0] Y_ZERO = '0;
  localparam logic signed [XWIDTH-1:0] X_HMAX = XWIDTH'(HRES - 1);
  localparam logic signed [YWIDTH-1:0] Y_VMAX = YWIDTH'(VRES - 1);

  state_t state_r, next_state_s;

  logic                   tri_ready_r;
  logic                   tri_done_r;
  logic                   pix_valid_r;
  logic [HWIDTH-1:0]      hcount_r, lo_x_r, hi_x_r;
  logic [VWIDTH-1:0]      vcount_r, lo_y_r, hi_y_r;
  logic [3*XWIDTH-1:0]    x_tri_r;
  logic [3*YWIDTH-1:0]    y_tri_r;
  logic [3*VAL_WIDTH-1:0] vals_r;
  logic [AINV_WIDTH-1:0]  iarea_r;

  logic                   tri_fire_s;
  logic                   pix_fire_s;
  logic                   pix_last_s;
  logic                   empty_s;
  logic signed [XWIDTH-1:0] xfmin_s, xfmax_s, lo_x_s, hi_x_s;
  logic signed [YWIDTH-1:0] yfmin_s, yfmax_s, lo_y_s, hi_y_s;

  // Signed min (want_max=0) or max (want_max=1) of the three packed x vertices.
  function automatic logic signed [XWIDTH-1:0] ext_x(input logic [3*XWIDTH-1:0] v,
                                                     input logic want_max);
    logic signed [XWIDTH-1:0] r;
    logic signed [XWIDTH-1:0] c;
    r = v[XWIDTH-1:0];
    for (int i = 1; i < 3; i++) begin
      c = v[i*XWIDTH +: XWIDTH];
      if (want_max ? (c > r) : (c < r)) r = c;
      else r = r;
    end
    return r;
  endfunction

  // Signed min (want_max=0) or max (want_max=1) of the three packed y vertices.
  function automatic logic signed [YWIDTH-1:0] ext_y(input logic [3*YWIDTH-1:0] v,
                                                     input logic want_max);
    logic signed [YWIDTH-1:0] r;
    logic signed [YWIDTH-1:0] c;
    r = v[YWIDTH-1:0];
    for (int i = 1; i < 3; i++) begin
      c = v[i*YWIDTH +: YWIDTH];
      if (want_max ? (c > r) : (c < r)) r = c;
      else r = r;
    end
    return r;
  endfunction

  // Bounding box of the latched triangle: floor by arithmetic shift, then clamp to screen.
  always_comb begin
    xfmin_s = ext_x(x_tri_r, 1'b0) >>> FRAC;
    xfmax_s = ext_x(x_tri_r, 1'b1) >>> FRAC;
    yfmin_s = ext_y(y_tri_r, 1'b0) >>> FRAC;
    yfmax_s = ext_y(y_tri_r, 1'b1) >>> FRAC;
    lo_x_s  = (xfmin_s < X_ZERO) ? X_ZERO : xfmin_s;
    hi_x_s  = (xfmax_s > X_HMAX) ? X_HMAX : xfmax_s;
    lo_y_s  = (yfmin_s < Y_ZERO) ? Y_ZERO : yfmin_s;
    hi_y_s  = (yfmax_s > Y_VMAX) ? Y_VMAX : yfmax_s;
    empty_s = (lo_x_s > hi_x_s) || (lo_y_s > hi_y_s);
  end

  // Last pixel of the box; only meaningful while a pixel is being offered.
  assign pix_last_s = pix_valid_r && (hcount_r == hi_x_r) && (vcount_r == hi_y_r);

  // Walker state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_r <= IDLE;
    else           state_r <= next_state_s;
  end

  // Next-state decode and handshake qualifiers.
  always_comb begin
    next_state_s = state_r;
    tri_fire_s   = 1'b0;
    pix_fire_s   = 1'b0;
    case (state_r)
      IDLE: begin
        tri_fire_s = bus.tri_valid_in && tri_ready_r;
        if (tri_fire_s) next_state_s = SETUP;
        else            next_state_s = IDLE;
      end
      SETUP: begin
        if (empty_s) next_state_s = IDLE;
        else         next_state_s = WALK;
      end
      WALK: begin
        pix_fire_s = bus.pix_ready_in && pix_valid_r;
        if (pix_fire_s && pix_last_s) next_state_s = IDLE;
        else                          next_state_s = WALK;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath: triangle latch, box bounds, raster counters and registered flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tri_ready_r <= 1'b0;
      tri_done_r  <= 1'b0;
      pix_valid_r <= 1'b0;
      hcount_r    <= '0;
      vcount_r    <= '0;
      lo_x_r      <= '0;
      hi_x_r      <= '0;
      lo_y_r      <= '0;
      hi_y_r      <= '0;
      x_tri_r     <= '0;
      y_tri_r     <= '0;
      vals_r      <= '0;
      iarea_r     <= '0;
    end else begin
      tri_ready_r <= (next_state_s == IDLE);
      tri_done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tri_fire_s) begin
            x_tri_r <= bus.x_tri_in;
            y_tri_r <= bus.y_tri_in;
            vals_r  <= bus.vals_in;
            iarea_r <= bus.iarea_in;
          end
        end
        SETUP: begin
          if (empty_s) begin
            tri_done_r <= 1'b1;
          end else begin
            lo_x_r      <= lo_x_s[HWIDTH-1:0];
            hi_x_r      <= hi_x_s[HWIDTH-1:0];
            lo_y_r      <= lo_y_s[VWIDTH-1:0];
            hi_y_r      <= hi_y_s[VWIDTH-1:0];
            hcount_r    <= lo_x_s[HWIDTH-1:0];
            vcount_r    <= lo_y_s[VWIDTH-1:0];
            pix_valid_r <= 1'b1;
          end
        end
        WALK: begin
          if (pix_fire_s) begin
            if (pix_last_s) begin
              pix_valid_r <= 1'b0;
              tri_done_r  <= 1'b1;
            end else if (hcount_r < hi_x_r) begin
              hcount_r <= hcount_r + HWIDTH'(1);
            end else begin
              hcount_r <= lo_x_r;
              vcount_r <= vcount_r + VWIDTH'(1);
            end
          end
        end
        default: pix_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.tri_ready_out = tri_ready_r;
  assign bus.tri_done_out  = tri_done_r;
  assign bus.pix_valid_out = pix_valid_r;
  assign bus.pix_last_out  = pix_last_s;
  assign bus.hcount_out    = hcount_r;
  assign bus.vcount_out    = vcount_r;
  assign bus.x_out         = {{(XWIDTH-HWIDTH-FRAC){1'b0}}, hcount_r, {FRAC{1'b0}}};
  assign bus.y_out         = {{(YWIDTH-VWIDTH-FRAC){1'b0}}, vcount_r, {FRAC{1'b0}}};
  assign bus.x_tri_out     = x_tri_r;
  assign bus.y_tri_out     = y_tri_r;
  assign bus.vals_out      = vals_r;
  assign bus.iarea_out     = iarea_r;

endmodule

// File: tb/tb_raster_bbox_walker.sv
// Directed bench for raster_bbox_walker: hand-computed boxes, raster order,
// stalls, clamping, empty boxes, single pixel and reset during a walk.
module tb_raster_bbox_walker;

  localparam int XW = 24;
  localparam int YW = 24;
  localparam int FR = 14;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [3*XW-1:0] cur_x;
  logic [3*YW-1:0] cur_y;

  raster_bbox_walker_if #(.XWIDTH(24), .YWIDTH(24), .VAL_WIDTH(16),
                          .AINV_WIDTH(16), .HWIDTH(9), .VWIDTH(8)) bus ();

  raster_bbox_walker dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a triangle (coords in 1/16384 units) and return just after the handshake edge.
  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    int n;
    n = 0;
    @(negedge clk);
    cur_x = {XW'(x2), XW'(x1), XW'(x0)};
    cur_y = {YW'(y2), YW'(y1), YW'(y0)};
    bus.x_tri_in     = cur_x;
    bus.y_tri_in     = cur_y;
    bus.vals_in      = {16'hC003, 16'hB002, 16'hA001};
    bus.iarea_in     = 16'h1234;
    bus.tri_valid_in = 1'b1;
    while (!bus.tri_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tri_ready_wait", 96'(n < 100), 96'(1));
    @(posedge clk);
    #1;
    bus.tri_valid_in = 1'b0;
  endtask

  // Consume a walk over [lo_x..hi_x]x[lo_y..hi_y]; stall applies ready pattern 1,0,0,1.
  task automatic walk(input string tag, input int lo_x, input int hi_x,
                      input int lo_y, input int hi_y, input bit stall);
    int h, v, got, bad, cyc, ph, total;
    bit rdy, exp_last;
    h = lo_x; v = lo_y; got = 0; bad = 0; cyc = 0; ph = 0;
    total = (hi_x - lo_x + 1) * (hi_y - lo_y + 1);
    @(negedge clk);
    check({tag, "_lat1_valid"}, 96'(bus.pix_valid_out), 96'(0));
    @(negedge clk);
    check({tag, "_lat2_valid"}, 96'(bus.pix_valid_out), 96'(1));
    check({tag, "_first_h"}, 96'(bus.hcount_out), 96'(lo_x));
    check({tag, "_first_v"}, 96'(bus.vcount_out), 96'(lo_y));
    check({tag, "_first_x"}, 96'(bus.x_out), 96'(lo_x << FR));
    check({tag, "_first_y"}, 96'(bus.y_out), 96'(lo_y << FR));
    check({tag, "_x_tri"}, 96'(bus.x_tri_out), 96'(cur_x));
    while (got < total && cyc < 70000) begin
      rdy = stall ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
      bus.pix_ready_in = rdy;
      exp_last = (h == hi_x) && (v == hi_y);
      if (!bus.pix_valid_out || bus.hcount_out !== 9'(h) || bus.vcount_out !== 8'(v) ||
          bus.x_out !== 24'(h << FR) || bus.y_out !== 24'(v << FR) ||
          bus.pix_last_out !== exp_last || bus.tri_done_out !== 1'b0) begin
        if (bad == 0)
          $display("  %s first bad pixel: got h=%0d v=%0d last=%0b want h=%0d v=%0d last=%0b",
                   tag, bus.hcount_out, bus.vcount_out, bus.pix_last_out, h, v, exp_last);
        bad++;
      end
      if (rdy) begin
        got++;
        if (h < hi_x) h++;
        else begin
          h = lo_x;
          v++;
        end
      end
      ph++;
      cyc++;
      @(negedge clk);
    end
    bus.pix_ready_in = 1'b1;
    check({tag, "_budget"}, 96'(cyc < 70000), 96'(1));
    check({tag, "_pixel_errors"}, 96'(bad), 96'(0));
    check({tag, "_pixel_count"}, 96'(got), 96'(total));
    check({tag, "_done_pulse"}, 96'(bus.tri_done_out), 96'(1));
    check({tag, "_valid_after"}, 96'(bus.pix_valid_out), 96'(0));
    check({tag, "_ready_after"}, 96'(bus.tri_ready_out), 96'(1));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 96'(bus.tri_done_out), 96'(0));
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.tri_valid_in = 1'b0;
    bus.pix_ready_in = 1'b1;
    bus.x_tri_in = '0;
    bus.y_tri_in = '0;
    bus.vals_in  = '0;
    bus.iarea_in = '0;
    cur_x = '0;
    cur_y = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 96'(bus.tri_ready_out), 96'(0));
    check("rst_valid", 96'(bus.pix_valid_out), 96'(0));
    check("rst_done",  96'(bus.tri_done_out), 96'(0));
    check("rst_last",  96'(bus.pix_last_out), 96'(0));
    check("rst_hcount", 96'(bus.hcount_out), 96'(0));
    check("rst_x_tri", 96'(bus.x_tri_out), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 96'(bus.tri_ready_out), 96'(1));

    // (1.5,1.2),(3.9,1.0),(2.0,2.7): box 1..3 x 1..2, no stall
    send_tri(24576, 19661, 63898, 16384, 32768, 44237);
    walk("tri1", 1, 3, 1, 2, 1'b0);
    check("tri1_vals", 96'(bus.vals_out), 96'({16'hC003, 16'hB002, 16'hA001}));
    check("tri1_iarea", 96'(bus.iarea_out), 96'(16'h1234));

    // same triangle with stalls
    send_tri(24576, 19661, 63898, 16384, 32768, 44237);
    walk("tri1_stall", 1, 3, 1, 2, 1'b1);

    // (-5,-5),(400,-5),(-5,200): clamped to full screen
    send_tri(-81920, -81920, 6553600, -81920, -81920, 3276800);
    walk("clamp", 0, 319, 0, 179, 1'b0);

    // entirely at x<0: no pixels, done two cycles after accept
    send_tri(-163840, 16384, -81920, 32768, -40960, 49152);
    seen = 0;
    @(negedge clk);
    seen += bus.pix_valid_out;
    check("empty_done_c1", 96'(bus.tri_done_out), 96'(0));
    @(negedge clk);
    seen += bus.pix_valid_out;
    check("empty_done_c2", 96'(bus.tri_done_out), 96'(1));
    @(negedge clk);
    seen += bus.pix_valid_out;
    check("empty_done_c3", 96'(bus.tri_done_out), 96'(0));
    check("empty_no_pixels", 96'(seen), 96'(0));

    // single pixel at (7,9)
    send_tri(116326, 150733, 122880, 162202, 129434, 155648);
    @(negedge clk);
    @(negedge clk);
    check("single_last", 96'(bus.pix_last_out), 96'(1));
    check("single_x", 96'(bus.x_out), 96'(7 << 14));
    check("single_y", 96'(bus.y_out), 96'(9 << 14));
    @(negedge clk);
    check("single_done", 96'(bus.tri_done_out), 96'(1));
    check("single_valid_after", 96'(bus.pix_valid_out), 96'(0));

    // reset in the middle of a walk, then a fresh triangle
    send_tri(24576, 19661, 63898, 16384, 32768, 44237);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 96'(bus.pix_valid_out), 96'(0));
    check("midrst_hcount", 96'(bus.hcount_out), 96'(0));
    check("midrst_ready", 96'(bus.tri_ready_out), 96'(0));
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += bus.tri_done_out;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen += bus.tri_done_out + bus.pix_valid_out;
    end
    check("midrst_no_done", 96'(seen), 96'(0));
    // (10,20),(11.5,20),(10,21.9): box 10..11 x 20..21
    send_tri(163840, 327680, 188416, 327680, 163840, 358810);
    walk("after_rst", 10, 11, 20, 21, 1'b1);
    check("after_rst_x_tri", 96'(bus.x_tri_out), 96'(cur_x));
    check("after_rst_y_tri", 96'(bus.y_tri_out), 96'(cur_y));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
